// File: rtl/decode_stage.sv
// RV32I decode stage: decodes LUI/ADDI/ADD/SUB, reads operands from a 32x32 register file
// with writeback bypass, and presents a registered ALU bundle behind a valid/ready handshake.
module decode_stage #(
  parameter int XLEN           = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            is_lui,
  output logic            is_i_type,
  output logic [3:0]      alu_ops,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [XLEN-1:0] regs [0:31];

  logic [4:0]      rs1_addr_p0, rs2_addr_p0, rd_addr_p0;
  logic            is_lui_p0, is_i_type_p0, illegal_p0, rd_we_p0;
  logic [3:0]      alu_ops_p0;
  logic [XLEN-1:0] imm_p0, rs1_data_p0, rs2_data_p0;
  logic            accept_p0, wb_live_p0;

  logic            vld_p1;
  logic [4:0]      rs1_addr_p1, rs2_addr_p1, rd_addr_p1;
  logic            is_lui_p1, is_i_type_p1, illegal_p1, rd_we_p1;
  logic [3:0]      alu_ops_p1;
  logic [XLEN-1:0] imm_p1, rs1_data_p1, rs2_data_p1;

  // Reads see a same-cycle writeback; x0 is hardwired to zero.
  function automatic logic [XLEN-1:0] bypass_read(input logic [4:0] addr, input logic [XLEN-1:0] stored,
                                                  input logic wb_hit, input logic [XLEN-1:0] wdata);
    if (addr == 5'd0)  return '0;
    else if (wb_hit)   return wdata;
    else               return stored;
  endfunction

  assign in_ready   = !vld_p1 || out_ready;
  assign accept_p0  = in_valid && in_ready;
  assign wb_live_p0 = wb_en && (wb_addr != 5'd0);

  // Stage p0: combinational decode and register-file read of the incoming instruction
  always_comb begin
    rs1_addr_p0  = instr[19:15];
    rs2_addr_p0  = instr[24:20];
    rd_addr_p0   = instr[11:7];
    is_lui_p0    = 1'b0;
    is_i_type_p0 = 1'b0;
    illegal_p0   = 1'b0;
    alu_ops_p0   = 4'b0000;
    imm_p0       = '0;
    unique case (instr[6:0])
      OPC_LUI: begin
        is_lui_p0 = 1'b1;
        imm_p0    = {12'b0, instr[31:12]};
      end
      OPC_OP_IMM: begin
        if (instr[14:12] == 3'b000) begin
          is_i_type_p0 = 1'b1;
          imm_p0       = {{(XLEN-12){instr[31]}}, instr[31:20]};
        end else begin
          illegal_p0 = 1'b1;
        end
      end
      OPC_OP: begin
        if (instr[14:12] == 3'b000 && instr[31:25] == 7'b0000000)      alu_ops_p0 = 4'b0000;
        else if (instr[14:12] == 3'b000 && instr[31:25] == 7'b0100000) alu_ops_p0 = 4'b0001;
        else                                                           illegal_p0 = 1'b1;
      end
      default: illegal_p0 = 1'b1;
    endcase
    if (illegal_p0) alu_ops_p0 = 4'b1111;
    rd_we_p0    = !illegal_p0 && (rd_addr_p0 != 5'd0);
    rs1_data_p0 = bypass_read(rs1_addr_p0, regs[rs1_addr_p0],
                              wb_live_p0 && (wb_addr == rs1_addr_p0), wb_data);
    rs2_data_p0 = bypass_read(rs2_addr_p0, regs[rs2_addr_p0],
                              wb_live_p0 && (wb_addr == rs2_addr_p0), wb_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET != 0) begin
        for (int i = 0; i < 32; i++) regs[i] <= '0;
      end
    end else if (wb_live_p0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Stage p1: registered output bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      rs1_addr_p1  <= '0;
      rs2_addr_p1  <= '0;
      rd_addr_p1   <= '0;
      is_lui_p1    <= 1'b0;
      is_i_type_p1 <= 1'b0;
      illegal_p1   <= 1'b0;
      rd_we_p1     <= 1'b0;
      alu_ops_p1   <= '0;
      imm_p1       <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
    end else if (accept_p0) begin
      vld_p1       <= 1'b1;
      rs1_addr_p1  <= rs1_addr_p0;
      rs2_addr_p1  <= rs2_addr_p0;
      rd_addr_p1   <= rd_addr_p0;
      is_lui_p1    <= is_lui_p0;
      is_i_type_p1 <= is_i_type_p0;
      illegal_p1   <= illegal_p0;
      rd_we_p1     <= rd_we_p0;
      alu_ops_p1   <= alu_ops_p0;
      imm_p1       <= imm_p0;
      rs1_data_p1  <= rs1_data_p0;
      rs2_data_p1  <= rs2_data_p0;
    end else begin
      if (out_ready) vld_p1 <= 1'b0;
      // A held bundle tracks writebacks to its source registers so it never issues stale operands.
      if (vld_p1 && !out_ready && wb_live_p0) begin
        if (wb_addr == rs1_addr_p1) rs1_data_p1 <= wb_data;
        if (wb_addr == rs2_addr_p1) rs2_data_p1 <= wb_data;
      end
    end
  end

  assign out_valid = vld_p1;
  assign is_lui    = is_lui_p1;
  assign is_i_type = is_i_type_p1;
  assign alu_ops   = alu_ops_p1;
  assign rs1_data  = rs1_data_p1;
  assign rs2_data  = rs2_data_p1;
  assign imm       = imm_p1;
  assign rd_addr   = rd_addr_p1;
  assign rd_we     = rd_we_p1;
  assign illegal   = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-decoded RV32I vectors checked with immediate assertions.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr;
  logic        is_lui, is_i_type, rd_we, illegal, wb_en;
  logic [3:0]  alu_ops;
  logic [31:0] rs1_data, rs2_data, imm, wb_data;
  logic [4:0]  rd_addr, wb_addr;
  int compared = 0;
  int mismatched = 0;

  decode_stage #(.XLEN(32), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .is_lui(is_lui), .is_i_type(is_i_type),
    .alu_ops(alu_ops), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd_addr(rd_addr),
    .rd_we(rd_we), .illegal(illegal), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst imm", imm, 0);
    chk("rst rs1", rs1_data, 0);
    chk("rst flags", {is_lui, is_i_type, rd_we, illegal, alu_ops, rd_addr}, 0);

    // add x6,x5,x0: x5 reads 0 after reset
    instr = 32'h0002_8333; in_valid = 1'b1;
    step();
    chk("x5 zero valid", out_valid, 1);
    chk("x5 zero rs1", rs1_data, 0);
    chk("add rd", rd_addr, 6);
    chk("add alu_ops", alu_ops, 0);

    // write x5 = 0x10, no accept; bundle drains
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h10;
    step();
    wb_en = 1'b0;
    chk("drain out_valid", out_valid, 0);

    // addi x5,x5,2
    instr = 32'h0022_8293; in_valid = 1'b1;
    step();
    chk("addi valid", out_valid, 1);
    chk("addi is_i_type", is_i_type, 1);
    chk("addi rs1", rs1_data, 32'h10);
    chk("addi imm", imm, 2);
    chk("addi rd", rd_addr, 5);
    chk("addi rd_we", rd_we, 1);

    // lui x1,0x12345 back-to-back
    instr = 32'h1234_50B7;
    step();
    chk("lui is_lui", is_lui, 1);
    chk("lui is_i_type", is_i_type, 0);
    chk("lui imm", imm, 32'h0001_2345);
    chk("lui rd_we", rd_we, 1);

    // sub x3,x1,x2
    instr = 32'h4020_81B3;
    step();
    chk("sub alu_ops", alu_ops, 1);
    chk("sub imm", imm, 0);
    chk("sub is_lui", is_lui, 0);

    // add x3,x1,x2 with same-cycle writeback to x1
    instr = 32'h0020_81B3; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEAD_BEEF;
    step();
    wb_en = 1'b0;
    chk("bypass rs1", rs1_data, 32'hDEAD_BEEF);
    chk("bypass alu_ops", alu_ops, 0);

    // add x4,x1,x2 then stall with a pending new instruction
    instr = 32'h0020_8233;
    step();
    out_ready = 1'b0; instr = 32'h0000_0073;
    #1;
    chk("stall in_ready c1", in_ready, 0);
    chk("held rs1", rs1_data, 32'hDEAD_BEEF);
    chk("held rs2 before", rs2_data, 0);
    step();
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h7;
    step();
    wb_en = 1'b0;
    chk("refresh rs2", rs2_data, 7);
    chk("refresh rs1 kept", rs1_data, 32'hDEAD_BEEF);
    chk("refresh rd kept", rd_addr, 4);
    chk("stall in_ready c2", in_ready, 0);
    chk("stall illegal kept", illegal, 0);
    step();
    chk("stall in_ready c3", in_ready, 0);
    chk("stall valid c3", out_valid, 1);
    chk("stall rs2 c3", rs2_data, 7);
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    chk("release in_ready", in_ready, 1);
    step();
    chk("release out_valid", out_valid, 0);

    // ecall is illegal
    instr = 32'h0000_0073; in_valid = 1'b1;
    step();
    chk("ecall illegal", illegal, 1);
    chk("ecall rd_we", rd_we, 0);
    chk("ecall alu_ops", alu_ops, 4'hF);
    chk("ecall imm", imm, 0);

    // slti x1,x1,2: OP-IMM with funct3 != 000 is illegal
    instr = 32'h0020_A093;
    step();
    chk("slti illegal", illegal, 1);
    chk("slti is_i_type", is_i_type, 0);

    // x0 write ignored, also within the accept cycle (add x7,x0,x0)
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h5;
    step();
    instr = 32'h0000_03B3; in_valid = 1'b1;
    step();
    wb_en = 1'b0;
    chk("x0 rs1", rs1_data, 0);
    chk("x0 rs2", rs2_data, 0);
    chk("x0 rd_we", rd_we, 1);

    // reset while a bundle is held, with a writeback that must be ignored
    instr = 32'h1234_54B7;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    step();
    rst = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst imm", imm, 0);
    chk("midrst is_lui", is_lui, 0);
    chk("midrst in_ready", in_ready, 1);

    // add x10,x9,x5: x9 never written, x5 cleared by reset
    instr = 32'h0054_8533; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post rst x9", rs1_data, 0);
    chk("post rst x5", rs2_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
